csa_exhaustive_checker: RTL and testbench

CSA_EXHAUSTIVE_CHECKER -- requirements
Module: csa_exhaustive_checker

---
 rtl/csa_exhaustive_checker.sv | 137 +++++++++++++
 tb/tb_csa_exhaustive_checker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/csa_exhaustive_checker.sv
// Exhaustive checker for a 4-bit adder: sweeps all 512 {c0,a,b} vectors,
// compares {cout,s} against a+b+c0 and records the error count and first failing vector.
module csa_exhaustive_checker #(
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic [3:0] a,
   output logic [3:0] b,
   output logic       c0,
   input  logic [3:0] s,
   input  logic       cout,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [9:0] err_count,
   output logic       fail_valid,
   output logic [3:0] fail_a,
   output logic [3:0] fail_b,
   output logic       fail_c0
);

   // state | meaning
   // IDLE  | waiting for start, vector outputs held at 0
   // RUN   | sweeping vectors, each held WAIT_CYC cycles then compared
   // DONE  | sweep complete, results held until next start
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam logic [3:0] HOLD_LOAD = 4'(WAIT_CYC - 1);
   localparam logic [8:0] IDX_LAST  = 9'd511;

   state_t     state_q, state_d;
   logic [8:0] idx_q, idx_d;
   logic [3:0] hold_q, hold_d;
   logic [9:0] err_q, err_d;
   logic       fail_valid_q, fail_valid_d;
   logic [8:0] fail_vec_q, fail_vec_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       pass_q, pass_d;
   logic [4:0] golden;
   logic       mismatch;

   // idx is kept at 0 outside RUN so the vector outputs come straight from flops
   assign {c0, a, b}                  = idx_q;
   assign {fail_c0, fail_a, fail_b}   = fail_vec_q;
   assign busy                        = busy_q;
   assign done                        = done_q;
   assign pass                        = pass_q;
   assign err_count                   = err_q;
   assign fail_valid                  = fail_valid_q;

   assign golden   = {1'b0, idx_q[7:4]} + {1'b0, idx_q[3:0]} + {4'b0, idx_q[8]};
   assign mismatch = ({cout, s} != golden);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         hold_q       <= '0;
         err_q        <= '0;
         fail_valid_q <= 1'b0;
         fail_vec_q   <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         hold_q       <= hold_d;
         err_q        <= err_d;
         fail_valid_q <= fail_valid_d;
         fail_vec_q   <= fail_vec_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         pass_q       <= pass_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      hold_d       = hold_q;
      err_d        = err_q;
      fail_valid_d = fail_valid_q;
      fail_vec_d   = fail_vec_q;
      busy_d       = busy_q;
      done_d       = done_q;
      pass_d       = pass_q;
      case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d      = RUN;
               idx_d        = '0;
               hold_d       = HOLD_LOAD;
               err_d        = '0;
               fail_valid_d = 1'b0;
               fail_vec_d   = '0;
               busy_d       = 1'b1;
               done_d       = 1'b0;
               pass_d       = 1'b0;
            end
         end
         RUN: begin
            if (hold_q != 4'd0) begin
               hold_d = hold_q - 4'd1;
            end else begin
               if (mismatch) begin
                  err_d = err_q + 10'd1;
                  if (!fail_valid_q) begin
                     fail_valid_d = 1'b1;
                     fail_vec_d   = idx_q;
                  end
               end
               if (idx_q == IDX_LAST) begin
                  state_d = DONE;
                  idx_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_d == 10'd0);
               end else begin
                  idx_d  = idx_q + 9'd1;
                  hold_d = HOLD_LOAD;
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_csa_exhaustive_checker.sv
// Directed bench for csa_exhaustive_checker: W=1 and W=3 instances driving
// behavioural adders with selectable faults.
module tb_csa_exhaustive_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start1, start3;
   logic [1:0] mode1;
   logic [3:0] a1, b1, s1, fa1, fb1;
   logic       c01, cout1, busy1, done1, pass1, fv1, fc01;
   logic [9:0] err1;
   logic [3:0] a3, b3, s3, fa3, fb3;
   logic       c03, cout3, busy3, done3, pass3, fv3, fc03;
   logic [9:0] err3;

   int checks = 0;
   int errors = 0;
   int n;
   bit busy_ok;

   csa_exhaustive_checker #(.WAIT_CYC(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c0(c01),
      .s(s1), .cout(cout1), .busy(busy1), .done(done1), .pass(pass1),
      .err_count(err1), .fail_valid(fv1), .fail_a(fa1), .fail_b(fb1), .fail_c0(fc01));

   csa_exhaustive_checker #(.WAIT_CYC(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .c0(c03),
      .s(s3), .cout(cout3), .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err3), .fail_valid(fv3), .fail_a(fa3), .fail_b(fb3), .fail_c0(fc03));

   // mode 0: correct, 1: cout stuck at 0, 2: s[0] inverted
   logic [4:0] sum1, sum3;
   always_comb begin
      sum1  = {1'b0, a1} + {1'b0, b1} + {4'b0, c01};
      s1    = sum1[3:0] ^ {3'b0, (mode1 == 2'd2)};
      cout1 = (mode1 == 2'd1) ? 1'b0 : sum1[4];
      sum3  = {1'b0, a3} + {1'b0, b3} + {4'b0, c03};
      s3    = sum3[3:0];
      cout3 = sum3[4];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic pulse1();
      start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start1 = 1'b0;
   endtask

   // counts edges after the accepting edge until done1 rises (bounded)
   task automatic wait_done1(input int limit, output int cnt, output bit bok);
      cnt = 0;
      bok = 1'b1;
      while (!done1 && cnt < limit) begin
         @(posedge clk);
         @(negedge clk);
         cnt++;
         if (busy1 == done1) bok = 1'b0;
      end
   endtask

   initial begin
      rst_n = 1'b0; start1 = 1'b0; start3 = 1'b0; mode1 = 2'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("idle_busy", busy1, 0);
      chk("idle_done", done1, 0);
      chk("idle_pass", pass1, 0);
      chk("idle_err", err1, 0);
      chk("idle_fv", fv1, 0);
      chk("idle_vec", {c01, a1, b1}, 0);
      chk("idle_fail", {fc01, fa1, fb1}, 0);

      // correct adder, full sweep with spot check of vector 423 = {1,10,7}
      pulse1();
      chk("run_busy", busy1, 1);
      chk("run_vec0", {c01, a1, b1}, 0);
      n = 0; busy_ok = 1'b1;
      while (!done1 && n < 600) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (busy1 == done1) busy_ok = 1'b0;
         if (n == 423) begin
            chk("spot_vec", {c01, a1, b1}, {1'b1, 4'd10, 4'd7});
            chk("spot_sum", {cout1, s1}, 5'd18);
            chk("spot_err", err1, 0);
         end
      end
      chk("ok_cycles", n, 512);
      chk("ok_busy_excl", busy_ok, 1);
      chk("ok_done", done1, 1);
      chk("ok_busy", busy1, 0);
      chk("ok_pass", pass1, 1);
      chk("ok_err", err1, 0);
      chk("ok_fv", fv1, 0);
      chk("ok_vec_zero", {c01, a1, b1}, 0);

      // cout stuck at 0: restart from DONE
      mode1 = 2'd1;
      pulse1();
      chk("restart_done", done1, 0);
      chk("restart_pass", pass1, 0);
      wait_done1(600, n, busy_ok);
      chk("cout0_cycles", n, 512);
      chk("cout0_err", err1, 256);
      chk("cout0_pass", pass1, 0);
      chk("cout0_fv", fv1, 1);
      chk("cout0_fail_a", fa1, 1);
      chk("cout0_fail_b", fb1, 15);
      chk("cout0_fail_c0", fc01, 0);

      // s[0] inverted: every vector fails
      mode1 = 2'd2;
      pulse1();
      wait_done1(600, n, busy_ok);
      chk("s0inv_err", err1, 512);
      chk("s0inv_pass", pass1, 0);
      chk("s0inv_fail", {fc01, fa1, fb1}, 0);
      chk("s0inv_fv", fv1, 1);

      // partial faulty sweep then mid-sweep reset
      pulse1();
      repeat (20) @(posedge clk);
      @(negedge clk);
      chk("part_err", err1, 20);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      chk("rst_err", err1, 0);
      chk("rst_fv", fv1, 0);
      chk("rst_busy", busy1, 0);

      // correct adder: ignored start at cycle 50, reset+start at cycle 100
      mode1 = 2'd0;
      pulse1();
      repeat (50) @(posedge clk);
      @(negedge clk);
      chk("c50_vec", {c01, a1, b1}, 50);
      pulse1();
      chk("ign_start_vec", {c01, a1, b1}, 51);
      chk("ign_start_busy", busy1, 1);
      repeat (48) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0; start1 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1; start1 = 1'b0;
      chk("rstwin_busy", busy1, 0);
      chk("rstwin_done", done1, 0);
      chk("rstwin_vec", {c01, a1, b1}, 0);
      @(posedge clk);
      @(negedge clk);
      chk("rstwin_stay_idle", busy1, 0);
      pulse1();
      wait_done1(600, n, busy_ok);
      chk("resweep_cycles", n, 512);
      chk("resweep_pass", pass1, 1);
      chk("resweep_busy_excl", busy_ok, 1);

      // WAIT_CYC = 3
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      n = 0;
      while (!done3 && n < 1700) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (n == 2) chk("w3_hold_vec0", {c03, a3, b3}, 0);
         if (n == 3) chk("w3_vec1", {c03, a3, b3}, 1);
      end
      chk("w3_cycles", n, 1536);
      chk("w3_pass", pass3, 1);
      chk("w3_err", err3, 0);
      start3 = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start3 = 1'b0;
      chk("w3_restart_done", done3, 0);
      chk("w3_restart_pass", pass3, 0);
      chk("w3_restart_busy", busy3, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
